uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver with a one-byte holding register.
//
// The line is oversampled by CLKS_PER_BIT clk cycles per bit. A falling edge
// on the synchronized line starts a frame. The start bit is re-checked at its
// midpoint, and every following bit is sampled once per bit period after that.
// Good bytes are loaded into dout. A bad stop bit is reported as a framing
// error. A byte that replaces an unread byte is reported as an overrun.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (even, >= 4)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   rxd          raw serial input, idle high
//   rd_en        consumer acknowledge of the held byte
//   dout         last correctly received byte
//   dout_rdy     dout holds an unread byte
//   rx_busy      a frame is in progress
//   framing_err  one-cycle pulse on a bad stop bit
//   overrun_err  one-cycle pulse when a byte lands while dout_rdy is set
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       dout_rdy,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Counter values at which a sample is taken: the midpoint of the start bit,
  // and then one full bit period later for every following bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    IDLE         = 4'b0001,
    START_BIT_ST = 4'b0010,
    DATA_BITS_ST = 4'b0100,
    STOP_BIT_ST  = 4'b1000
  } state_t;

  // Current-state registers.
  logic [1:0]       sync_q;
  logic             rxs;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_count_q;
  logic [7:0]       shift_q;
  logic [7:0]       dout_q;
  logic             dout_rdy_q;
  logic             framing_err_q;
  logic             overrun_err_q;
  // Cleared by a framing error. Set again once the line has been seen high,
  // so a held-low (break) line cannot start a new frame.
  logic             armed_q;

  // Next-state values.
  state_t           state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_count_d;
  logic [7:0]       shift_d;
  logic [7:0]       dout_d;
  logic             dout_rdy_d;
  logic             framing_err_d;
  logic             overrun_err_d;
  logic             armed_d;

  // The second synchronizer stage is the only view of the line the FSM uses.
  assign rxs = sync_q[1];

  // NOTE: every signal assigned here gets a default value first. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    bit_count_d   = bit_count_q;
    shift_d       = shift_q;
    dout_d        = dout_q;
    dout_rdy_d    = dout_rdy_q;
    framing_err_d = 1'b0;
    overrun_err_d = 1'b0;
    armed_d       = armed_q;

    // The acknowledge is applied first. A load in the STOP_BIT_ST branch
    // below overrides it, so a new byte always wins over a coincident read.
    if (rd_en && dout_rdy_q) begin
      dout_rdy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs) begin
          armed_d = 1'b1;
        end
        if (!rxs && armed_q) begin
          state_d = START_BIT_ST;
        end
      end

      START_BIT_ST: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            // The line went high again before the midpoint: a glitch, not a start.
            state_d = IDLE;
          end else begin
            state_d     = DATA_BITS_ST;
            bit_count_d = '0;
          end
        end
      end

      DATA_BITS_ST: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d       = '0;
          // LSB first: after eight shifts, bit 0 sits in shift_q[0].
          shift_d     = {rxs, shift_q[7:1]};
          bit_count_d = bit_count_q + 3'd1;
          if (bit_count_q == 3'd7) begin
            state_d = STOP_BIT_ST;
          end
        end
      end

      STOP_BIT_ST: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            dout_d        = shift_q;
            dout_rdy_d    = 1'b1;
            overrun_err_d = dout_rdy_q && !rd_en;
          end else begin
            framing_err_d = 1'b1;
            armed_d       = 1'b0;
          end
        end
      end

      default: begin
        // Any encoding that is not one-hot returns to IDLE.
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its input from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= 2'b11;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_count_q   <= '0;
      shift_q       <= '0;
      dout_q        <= '0;
      dout_rdy_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      sync_q        <= {sync_q[0], rxd};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_count_q   <= bit_count_d;
      shift_q       <= shift_d;
      dout_q        <= dout_d;
      dout_rdy_q    <= dout_rdy_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
      armed_q       <= armed_d;
    end
  end

  assign dout        = dout_q;
  assign dout_rdy    = dout_rdy_q;
  assign rx_busy     = (state_q != IDLE);
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at CLKS_PER_BIT = 16.
//
// Frames are driven bit by bit on the falling clock edge. A reference model
// tracks the expected dout, dout_rdy and error-pulse totals from the frame
// contents and the rd_en/rst timing. A monitor on the falling edge counts the
// pulses and records when rx_busy and dout_rdy change.
module tb_uart_rx;

  localparam int CPB = 16;
  // Offset, counted from the cycle rxd first goes low, of the cycle in which
  // the stop bit is sampled: 2 synchronizer cycles, then half a bit period,
  // then 9 full bit periods. The load is visible one cycle later.
  localparam int LOAD_OFS = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_rdy;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_rdy    (dout_rdy),
    .rx_busy     (rx_busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse totals and the cycles of the most recent output edges.
  int   fe_cnt = 0, ov_cnt = 0;
  int   busy_rise = -1, busy_fall = -1, rdy_rise = -1;
  logic busy_prev = 1'b0, rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (framing_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (rx_busy && !busy_prev) busy_rise = cyc;
    if (!rx_busy && busy_prev) busy_fall = cyc;
    if (dout_rdy && !rdy_prev) rdy_rise = cyc;
    busy_prev = rx_busy;
    rdy_prev  = dout_rdy;
  end

  // Reference model state.
  logic [7:0] ref_dout = 8'h00;
  logic       ref_rdy = 1'b0;
  int         exp_fe = 0, exp_ov = 0;

  int n_checks = 0, n_pass = 0;
  int frame_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    ref_rdy = 1'b0;
  endtask

  // Drive one 10-bit frame. rd_at / rst_at are cycle offsets from the start
  // of the frame at which to pulse rd_en (1 cycle) or rst (2 cycles); -1 = none.
  // The line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int rd_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) frame_start = cyc;
      rxd   = bits[i / CPB];
      rd_en = (i == rd_at);
      rst   = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 2);
      if (rst_at >= 0 && i == rst_at + 1) begin
        #1;
        check("in_reset_busy", rx_busy, 0);
        check("in_reset_rdy", dout_rdy, 0);
        check("in_reset_dout", dout, 8'h00);
      end
    end
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b0;
  endtask

  // Expected effect of one frame on the outputs.
  task automatic model_frame(input logic [7:0] data, input logic stop,
                             input int rd_at, input int rst_at);
    if (rst_at >= 0) begin
      // Reset aborts the frame; the remaining bits of 0xFF look like idle line.
      ref_dout = 8'h00;
      ref_rdy  = 1'b0;
    end else begin
      if (rd_at >= 0 && rd_at < LOAD_OFS) ref_rdy = 1'b0;
      if (stop) begin
        if (ref_rdy && rd_at != LOAD_OFS) exp_ov++;
        ref_dout = data;
        ref_rdy  = 1'b1;
      end else begin
        exp_fe++;
        if (rd_at == LOAD_OFS) ref_rdy = 1'b0;
      end
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] data, input logic stop,
                       input int rd_at, input int rst_at);
    send_frame(data, stop, rd_at, rst_at);
    model_frame(data, stop, rd_at, rst_at);
    #1;
    check({tag, "_dout"}, dout, ref_dout);
    check({tag, "_rdy"}, dout_rdy, ref_rdy);
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_ov"}, ov_cnt, exp_ov);
  endtask

  initial begin
    int n0, rise0, rd_at, gap;
    logic [7:0] data;
    logic stop;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_dout", dout, 8'h00);
    check("reset_rdy", dout_rdy, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_pulses", {30'd0, framing_err, overrun_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // 0xA5, good stop: exact timing of busy and dout_rdy.
    frame("a5", 8'hA5, 1'b1, -1, -1);
    check("a5_busy_rise", busy_rise, frame_start + 3);
    check("a5_busy_fall", busy_fall, frame_start + LOAD_OFS + 1);
    check("a5_rdy_rise", rdy_rise, frame_start + LOAD_OFS + 1);
    idle(5);

    // Read the byte, then a 4-cycle glitch must be rejected at its midpoint.
    rd_pulse();
    #1;
    check("rd_clears_rdy", dout_rdy, 0);
    @(negedge clk);
    n0 = cyc;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    idle(30);
    #1;
    check("glitch_busy_rise", busy_rise, n0 + 3);
    check("glitch_busy_fall", busy_fall, n0 + 11);
    check("glitch_rdy", dout_rdy, ref_rdy);
    check("glitch_pulses", fe_cnt + ov_cnt, exp_fe + exp_ov);

    // 0x3C with a bad stop bit, then a 300-cycle break: no new frame.
    frame("fe3c", 8'h3C, 1'b0, -1, -1);
    rise0 = busy_rise;
    repeat (300) @(negedge clk);
    #1;
    check("break_no_start", busy_rise, rise0);
    check("break_busy", rx_busy, 0);
    idle(20);
    frame("after_break", 8'h77, 1'b1, -1, -1);

    // Back-to-back 0x11, 0x22 with no read: one overrun at the second load.
    rd_pulse();
    frame("b2b_11", 8'h11, 1'b1, -1, -1);
    frame("b2b_22", 8'h22, 1'b1, -1, -1);
    idle(3);
    rd_pulse();
    #1;
    check("b2b_rd_clears", dout_rdy, 0);
    idle(5);

    // Reset partway through 0xFF, then 0x5A is received normally.
    frame("rst_ff", 8'hFF, 1'b1, -1, 72);
    idle(5);
    frame("after_rst", 8'h5A, 1'b1, -1, -1);

    // rd_en coinciding with a load: the load wins, no overrun.
    idle(4);
    frame("rd_at_load", 8'h96, 1'b1, LOAD_OFS, -1);

    // Randomized frames against the model.
    for (int k = 0; k < 24; k++) begin
      data = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 3))
        0:       rd_at = 40;
        1:       rd_at = LOAD_OFS;
        default: rd_at = -1;
      endcase
      frame("rand", data, stop, rd_at, -1);
      gap = $urandom_range(2, 20);
      idle(gap);
    end

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
